// File: rtl/send_cmd_pcie_mc_pkg.sv
// rtl/send_cmd_pcie_mc_pkg.sv - register map, status/event bit indices and channel FSM states
package send_cmd_pcie_pkg;

  localparam logic [31:0] ID_VALUE = 32'h5C0D_0200;

  localparam logic [15:0] REG_ID        = 16'h0000;
  localparam logic [15:0] REG_STATUS    = 16'h0001;
  localparam logic [15:0] REG_EVENTS    = 16'h0002;
  localparam logic [15:0] REG_DDR_SETUP = 16'h0003;
  localparam logic [15:0] REG_CONTROL   = 16'h0004;
  localparam logic [11:0] PAGE_PUSH     = 12'h001;
  localparam logic [11:0] PAGE_CHSTAT   = 12'h002;

  localparam int STAT_CAL_SUCCESS = 0;
  localparam int STAT_CAL_FAIL    = 1;
  localparam int STAT_SETUP_DONE  = 2;
  localparam int STAT_MAIN_RESET  = 3;
  localparam int STAT_DDR_AV_RST  = 4;
  localparam int STAT_BOARD_RESET = 5;
  localparam int STAT_SETUP_CMD   = 6;

  localparam int EV_MAIN_RESET  = 0;
  localparam int EV_DDR_AV_RST  = 1;
  localparam int EV_BOARD_RESET = 2;

  localparam int CTRL_IRQ_EN = 16;
  localparam int CTRL_FLUSH  = 31;
  localparam int CHS_OVF     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } chan_state_e;

endpackage

// File: rtl/send_cmd_pcie_mc_if.sv
// rtl/send_cmd_pcie_mc_if.sv - Avalon-MM slave register bus
interface send_cmd_pcie_mc_if;
  logic        avalon_mm_read;
  logic        avalon_mm_write;
  logic [15:0] avalon_mm_addr;
  logic [31:0] avalon_mm_write_data;
  logic [31:0] avalon_mm_read_data;
  logic        avalon_mm_rd_valid;

  modport master (
    output avalon_mm_read, avalon_mm_write, avalon_mm_addr, avalon_mm_write_data,
    input  avalon_mm_read_data, avalon_mm_rd_valid
  );
  modport slave (
    input  avalon_mm_read, avalon_mm_write, avalon_mm_addr, avalon_mm_write_data,
    output avalon_mm_read_data, avalon_mm_rd_valid
  );
endinterface

// File: rtl/send_cmd_pcie_mc_chan.sv
// rtl/send_cmd_pcie_mc_chan.sv - one channel: command queue, dispatch FSM, completion count, overflow flag
module send_cmd_chan
  import send_cmd_pcie_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int QDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              cal_ok_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_data_i,
  input  logic              ovf_clr_i,
  input  logic              ack_i,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic              send_cmd_o,
  output logic [6:0]        level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [15:0]       count_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(QDEPTH);

  logic [ADDR_W-1:0] mem_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       level_q, level_d;
  chan_state_e       state_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic              send_cmd_q;
  logic [15:0]       count_q;
  logic              ovf_q, ovf_d;
  logic              full, empty, pop, push_ok, ovf_set;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  // A flush owns the queue for its cycle: no pop, and any push that cycle is discarded.
  assign pop     = (state_q == IDLE) & en_i & cal_ok_i & ~empty & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full | pop);
  assign ovf_set = push_i & ~flush_i & full & ~pop;
  assign level_d = level_q + (PW+1)'(push_ok) - (PW+1)'(pop);
  assign ovf_d   = (ovf_q & ~ovf_clr_i) | ovf_set;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
      start_addr_q <= '0;
      send_cmd_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        level_q <= level_d;
      end
      case (state_q)
        IDLE: if (pop) begin
          state_q      <= LOAD;
          start_addr_q <= mem_q[rd_ptr_q];
        end
        LOAD: begin
          state_q    <= ISSUE;
          send_cmd_q <= 1'b1;
        end
        ISSUE: if (ack_i) begin
          state_q    <= IDLE;
          send_cmd_q <= 1'b0;
          count_q    <= count_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_addr_o = start_addr_q;
  assign send_cmd_o   = send_cmd_q;
  assign level_o      = 7'(level_q);
  assign full_o       = full;
  assign empty_o      = empty;
  assign busy_o       = (state_q != IDLE);
  assign ovf_o        = ovf_q;
  assign count_o      = count_q;

endmodule

// File: rtl/send_cmd_pcie_mc.sv
// rtl/send_cmd_pcie_mc.sv - multi-channel command dispatcher with Avalon-MM register file
module send_cmd_pcie_mc
  import send_cmd_pcie_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 6,
  parameter int QDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  send_cmd_pcie_mc_if.slave        bus,
  output logic [NUM_CH*ADDR_W-1:0] start_ram_addr_o,
  output logic [NUM_CH-1:0]        send_cmd_o,
  input  logic [NUM_CH-1:0]        send_ack_i,
  input  logic                     ddr_local_cal_success_i,
  input  logic                     ddr_local_cal_fail_i,
  input  logic                     ddr_setup_done_i,
  input  logic                     system_main_reset_i,
  input  logic                     ddr_avalon_rst_i,
  input  logic                     board_reset_i,
  output logic                     ddr_setup_cmd_o,
  output logic                     irq_o
);
  logic [15:0]       addr;
  logic [31:0]       wdata, rd_mux, rdata_q;
  logic              wr, rd_valid_q, wr_control, flush, cal_ok;
  logic [NUM_CH-1:0] ch_en_q, push_sel, ovf_clr, ovf, full, empty, busy;
  logic              irq_en_q, ddr_setup_q;
  logic [2:0]        rst_now, rst_prev_q, events_q, events_d, ev_clr;
  logic [6:0]        status;
  logic [6:0]        level [NUM_CH];
  logic [15:0]       count [NUM_CH];
  logic [31:0]       ch_stat [NUM_CH];
  logic              unused_wdata;

  assign addr         = bus.avalon_mm_addr;
  assign wdata        = bus.avalon_mm_write_data;
  assign wr           = bus.avalon_mm_write;
  assign unused_wdata = ^wdata;
  assign wr_control   = wr & (addr == REG_CONTROL);
  assign flush        = wr_control & wdata[CTRL_FLUSH];
  assign cal_ok       = ddr_local_cal_success_i & ~ddr_local_cal_fail_i;

  always_comb begin
    push_sel = '0;
    ovf_clr  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_sel[c] = wr & (addr[15:4] == PAGE_PUSH) & (addr[3:0] == 4'(c));
      ovf_clr[c]  = wr & (addr[15:4] == PAGE_CHSTAT) & (addr[3:0] == 4'(c)) & wdata[CHS_OVF];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    send_cmd_chan #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en_i        (ch_en_q[c]),
      .cal_ok_i    (cal_ok),
      .flush_i     (flush),
      .push_i      (push_sel[c]),
      .push_data_i (wdata[ADDR_W-1:0]),
      .ovf_clr_i   (ovf_clr[c]),
      .ack_i       (send_ack_i[c]),
      .start_addr_o(start_ram_addr_o[c*ADDR_W +: ADDR_W]),
      .send_cmd_o  (send_cmd_o[c]),
      .level_o     (level[c]),
      .full_o      (full[c]),
      .empty_o     (empty[c]),
      .busy_o      (busy[c]),
      .ovf_o       (ovf[c]),
      .count_o     (count[c])
    );
    assign ch_stat[c] = {count[c], 4'b0, ovf[c], busy[c], empty[c], full[c], 1'b0, level[c]};
  end

  always_comb begin
    rst_now = '0;
    rst_now[EV_MAIN_RESET]  = system_main_reset_i;
    rst_now[EV_DDR_AV_RST]  = ddr_avalon_rst_i;
    rst_now[EV_BOARD_RESET] = board_reset_i;
  end
  // Edge wins over a same-cycle W1C so a fresh event is never lost.
  assign ev_clr   = (wr && addr == REG_EVENTS) ? wdata[2:0] : 3'b0;
  assign events_d = (events_q & ~ev_clr) | (rst_now & ~rst_prev_q);

  always_comb begin
    status = '0;
    status[STAT_CAL_SUCCESS] = ddr_local_cal_success_i;
    status[STAT_CAL_FAIL]    = ddr_local_cal_fail_i;
    status[STAT_SETUP_DONE]  = ddr_setup_done_i;
    status[STAT_MAIN_RESET]  = system_main_reset_i;
    status[STAT_DDR_AV_RST]  = ddr_avalon_rst_i;
    status[STAT_BOARD_RESET] = board_reset_i;
    status[STAT_SETUP_CMD]   = ddr_setup_q;
  end

  always_comb begin
    rd_mux = '0;
    if (addr == REG_ID)           rd_mux = ID_VALUE;
    else if (addr == REG_STATUS)  rd_mux = 32'(status);
    else if (addr == REG_EVENTS)  rd_mux = 32'(events_q);
    else if (addr == REG_CONTROL) begin
      rd_mux[NUM_CH-1:0]  = ch_en_q;
      rd_mux[CTRL_IRQ_EN] = irq_en_q;
    end else if (addr[15:4] == PAGE_CHSTAT) begin
      for (int c = 0; c < NUM_CH; c++)
        if (addr[3:0] == 4'(c)) rd_mux = ch_stat[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_en_q     <= '0;
      irq_en_q    <= 1'b0;
      ddr_setup_q <= 1'b0;
      rst_prev_q  <= '0;
      events_q    <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      if (wr_control) begin
        ch_en_q  <= wdata[NUM_CH-1:0];
        irq_en_q <= wdata[CTRL_IRQ_EN];
      end
      if (ddr_setup_q) begin
        if (ddr_setup_done_i) ddr_setup_q <= 1'b0;
      end else if (wr && addr == REG_DDR_SETUP && wdata[0]) begin
        ddr_setup_q <= 1'b1;
      end
      rst_prev_q <= rst_now;
      events_q   <= events_d;
      rd_valid_q <= bus.avalon_mm_read;
      if (bus.avalon_mm_read) rdata_q <= rd_mux;
    end
  end

  assign bus.avalon_mm_read_data = rdata_q;
  assign bus.avalon_mm_rd_valid  = rd_valid_q;
  assign ddr_setup_cmd_o         = ddr_setup_q;
  assign irq_o                   = irq_en_q & ((|events_q) | (|ovf));

endmodule

// File: tb/tb_send_cmd_pcie_mc.sv
// tb/tb_send_cmd_pcie_mc.sv - scoreboard bench for send_cmd_pcie_mc
module tb_send_cmd_pcie_mc;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 6;
  localparam int QDEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  send_cmd_pcie_mc_if bus();
  logic [NUM_CH*ADDR_W-1:0] start_ram_addr;
  logic [NUM_CH-1:0]        send_cmd;
  logic [NUM_CH-1:0]        send_ack = '0;
  logic cal_success = 1'b1, cal_fail = 1'b0, setup_done = 1'b0;
  logic main_reset = 1'b0, ddr_av_rst = 1'b0, board_reset = 1'b0;
  logic ddr_setup_cmd, irq;

  send_cmd_pcie_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus                    (bus),
    .start_ram_addr_o       (start_ram_addr),
    .send_cmd_o             (send_cmd),
    .send_ack_i             (send_ack),
    .ddr_local_cal_success_i(cal_success),
    .ddr_local_cal_fail_i   (cal_fail),
    .ddr_setup_done_i       (setup_done),
    .system_main_reset_i    (main_reset),
    .ddr_avalon_rst_i       (ddr_av_rst),
    .board_reset_i          (board_reset),
    .ddr_setup_cmd_o        (ddr_setup_cmd),
    .irq_o                  (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Read scoreboard
  logic [31:0] rd_exp_q [$];
  string       rd_tag_q [$];
  logic        rd_seen = 1'b0;
  string       rd_tag;
  logic [31:0] rd_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_seen || bus.avalon_mm_rd_valid)
        check_eq("rd_valid_timing", 32'(bus.avalon_mm_rd_valid), 32'(rd_seen));
      if (bus.avalon_mm_rd_valid) begin
        if (rd_exp_q.size() == 0) check_eq("rd_sb_pending", 32'(rd_exp_q.size()), 32'd1);
        else begin
          rd_tag = rd_tag_q.pop_front();
          rd_exp = rd_exp_q.pop_front();
          check_eq(rd_tag, bus.avalon_mm_read_data, rd_exp);
        end
      end
    end
    rd_seen <= bus.avalon_mm_read;
  end

  // Dispatch scoreboard: expected start address checked on each send_cmd rising edge
  logic [ADDR_W-1:0] cmd_exp_q [NUM_CH][$];
  logic [NUM_CH-1:0] send_prev = '0;
  int                rise_cnt [NUM_CH];

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (send_cmd[c] && !send_prev[c]) begin
        rise_cnt[c] <= rise_cnt[c] + 1;
        if (cmd_exp_q[c].size() == 0)
          check_eq($sformatf("dispatch_sb_ch%0d", c), 32'(cmd_exp_q[c].size()), 32'd1);
        else
          check_eq($sformatf("start_ram_addr_ch%0d", c),
                   32'(start_ram_addr[c*ADDR_W +: ADDR_W]), 32'(cmd_exp_q[c].pop_front()));
      end
    end
    send_prev <= send_cmd;
  end

  // Downstream engine model: acks a request on its second ISSUE cycle
  logic ack_en [NUM_CH] = '{default: 1'b0};
  int   ack_cnt [NUM_CH] = '{default: 0};
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (send_ack[c]) send_ack[c] = 1'b0;
        else if (send_cmd[c] && ack_en[c]) begin
          if (ack_cnt[c] == 1) begin
            send_ack[c] = 1'b1;
            ack_cnt[c]  = 0;
          end else ack_cnt[c]++;
        end
      end
    end
  end

  task automatic av_cycle(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.avalon_mm_read       = rd;
    bus.avalon_mm_write      = wr;
    bus.avalon_mm_addr       = a;
    bus.avalon_mm_write_data = wd;
    @(posedge clk); #1;
    bus.avalon_mm_read  = 1'b0;
    bus.avalon_mm_write = 1'b0;
  endtask

  task automatic av_write(input logic [15:0] a, input logic [31:0] d);
    av_cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic av_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    rd_tag_q.push_back(tag);
    av_cycle(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic push_cmd(input int c, input logic [ADDR_W-1:0] a, input bit dispatch);
    if (dispatch) cmd_exp_q[c].push_back(a);
    av_write(16'h0010 + 16'(c), 32'(a));
  endtask

  function automatic int cmd_pending();
    int n = 0;
    for (int c = 0; c < NUM_CH; c++) n += cmd_exp_q[c].size();
    return n;
  endfunction

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((rd_exp_q.size() != 0 || cmd_pending() != 0 || send_cmd != '0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic measure_issue(input string tag, input int c, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!send_cmd[c] && lat < 20);
    check_eq(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    bus.avalon_mm_read       = 1'b0;
    bus.avalon_mm_write      = 1'b0;
    bus.avalon_mm_addr       = '0;
    bus.avalon_mm_write_data = '0;
    ack_en[0] = 1'b1;
    ack_en[1] = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_send_cmd", 32'(send_cmd), 32'h0);
    check_eq("rst_start_addr", 32'(start_ram_addr), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_setup_cmd", 32'(ddr_setup_cmd), 32'h0);
    check_eq("rst_rd_valid", 32'(bus.avalon_mm_rd_valid), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    av_read("id", 16'h0000, 32'h5C0D_0200);
    av_read("status_cal", 16'h0001, 32'h0000_0001);
    av_read("control_rst", 16'h0004, 32'h0);

    // Channel 1 dispatch
    av_write(16'h0004, 32'h0000_0002);
    push_cmd(1, 6'h05, 1'b1);
    measure_issue("push_to_issue_ch1", 1, 3);
    push_cmd(1, 6'h2A, 1'b1);
    wait_drain("drain_ch1");
    check_eq("send_cmd_pulses_ch1", 32'(rise_cnt[1]), 32'd2);
    av_read("chstat1_done", 16'h0021, 32'h0002_0200);

    // Overflow on disabled channel 0
    for (int i = 0; i < QDEPTH + 1; i++) push_cmd(0, 6'(i + 1), 1'b0);
    av_read("chstat0_full_ovf", 16'h0020, 32'h0000_0908);
    @(negedge clk);
    check_eq("irq_masked", 32'(irq), 32'h0);
    rd_exp_q.push_back(32'h0000_0002);
    rd_tag_q.push_back("control_rd_during_wr");
    av_cycle(1'b1, 1'b1, 16'h0004, 32'h0001_0002);
    @(negedge clk);
    check_eq("irq_ovf", 32'(irq), 32'h1);
    av_write(16'h0020, 32'h0000_0800);
    @(negedge clk);
    check_eq("irq_ovf_cleared", 32'(irq), 32'h0);
    av_read("chstat0_ovf_clr", 16'h0020, 32'h0000_0108);
    av_write(16'h0004, 32'h8001_0002);
    av_read("chstat0_flushed", 16'h0020, 32'h0000_0200);
    av_read("control_flush_rd0", 16'h0004, 32'h0001_0002);
    av_write(16'h0014, 32'h0000_0011);
    av_read("unmapped_chstat", 16'h0024, 32'h0);
    av_read("unmapped_reg", 16'h0005, 32'h0);

    // Calibration gating on channel 0
    @(posedge clk); #1 cal_success = 1'b0;
    av_write(16'h0004, 32'h0001_0001);
    push_cmd(0, 6'h33, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("no_issue_cal_low", 32'(send_cmd), 32'h0);
    av_read("status_cal_low", 16'h0001, 32'h0);
    @(posedge clk); #1 cal_success = 1'b1;
    measure_issue("cal_to_issue_ch0", 0, 3);
    wait_drain("drain_ch0");
    av_read("chstat0_count", 16'h0020, 32'h0001_0200);

    // DDR setup sequencing
    av_write(16'h0003, 32'h1);
    @(negedge clk);
    check_eq("setup_cmd_set", 32'(ddr_setup_cmd), 32'h1);
    av_read("status_setup", 16'h0001, 32'h0000_0041);
    av_write(16'h0003, 32'h1);
    check_eq("setup_cmd_hold", 32'(ddr_setup_cmd), 32'h1);
    @(posedge clk); #1 setup_done = 1'b1;
    @(posedge clk); #1;
    check_eq("setup_cmd_cleared", 32'(ddr_setup_cmd), 32'h0);
    setup_done = 1'b0;

    // Reset events
    @(posedge clk); #1 board_reset = 1'b1;
    @(posedge clk); #1 board_reset = 1'b0;
    av_read("events_board", 16'h0002, 32'h0000_0004);
    @(negedge clk);
    check_eq("irq_event", 32'(irq), 32'h1);
    @(posedge clk); #1;
    board_reset = 1'b1;
    bus.avalon_mm_write      = 1'b1;
    bus.avalon_mm_addr       = 16'h0002;
    bus.avalon_mm_write_data = 32'h4;
    @(posedge clk); #1;
    bus.avalon_mm_write = 1'b0;
    board_reset = 1'b0;
    av_read("events_edge_vs_w1c", 16'h0002, 32'h0000_0004);
    @(posedge clk); #1 main_reset = 1'b1;
    @(posedge clk); #1 main_reset = 1'b0;
    av_write(16'h0002, 32'h4);
    av_read("events_main_only", 16'h0002, 32'h0000_0001);
    av_write(16'h0002, 32'h1);
    av_read("events_cleared", 16'h0002, 32'h0);
    @(negedge clk);
    check_eq("irq_idle", 32'(irq), 32'h0);

    wait_drain("drain_final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
